// File: rtl/pipelined_divider_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_divider_pkg
// Shared constants for the pipelined signed/unsigned divider and its stage.
//   TAG_WIDTH : width of the opaque tag carried alongside each operation.
// -----------------------------------------------------------------------------
package pipelined_divider_pkg;

  // Width of the operation tag travelling with each division.
  localparam int unsigned TAG_WIDTH = 6;

endpackage : pipelined_divider_pkg

// File: rtl/pipelined_divider_stage.sv
// -----------------------------------------------------------------------------
// pipelined_divider_stage
// One restoring-division step plus its pipeline registers. Each stage shifts
// the next dividend-magnitude bit (MSB first) into the partial remainder,
// compares it against the divisor, subtracts when it fits and shifts the
// resolved quotient bit into the LSB of the work register.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   i_valid / o_valid     : stage valid in / registered stage valid out
//   i_rem / o_rem         : partial remainder (dividend_width bits)
//   i_work / o_work       : remaining dividend bits (MSBs) and quotient bits (LSBs)
//   i_divisor / o_divisor : unsigned divisor carried down the pipe
//   i_neg / o_neg         : dividend sign carried down the pipe
//   i_tag / o_tag         : operation tag carried down the pipe
// -----------------------------------------------------------------------------
module pipelined_divider_stage
  import pipelined_divider_pkg::*;
#(
  parameter int unsigned dividend_width = 32,
  parameter int unsigned divisor_width  = 24
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_valid,
  input  logic [dividend_width-1:0] i_rem,
  input  logic [dividend_width-1:0] i_work,
  input  logic [divisor_width-1:0]  i_divisor,
  input  logic                      i_neg,
  input  logic [TAG_WIDTH-1:0]      i_tag,
  output logic                      o_valid,
  output logic [dividend_width-1:0] o_rem,
  output logic [dividend_width-1:0] o_work,
  output logic [divisor_width-1:0]  o_divisor,
  output logic                      o_neg,
  output logic [TAG_WIDTH-1:0]      o_tag
);

  // The partial remainder is kept dividend_width wide (not divisor_width) so
  // that a zero divisor, which accepts every trial, accumulates the whole
  // magnitude without overflowing.
  logic [dividend_width:0]   w_trial;
  logic [dividend_width:0]   w_div_ext;
  logic [dividend_width-1:0] w_div_w;
  logic [dividend_width-1:0] w_diff;
  logic [dividend_width-1:0] w_rem_next;
  logic [dividend_width-1:0] w_work_next;
  logic                      w_ge;

  logic                      r_valid;
  logic [dividend_width-1:0] r_rem;
  logic [dividend_width-1:0] r_work;
  logic [divisor_width-1:0]  r_divisor;
  logic                      r_neg;
  logic [TAG_WIDTH-1:0]      r_tag;

  // Restoring step: shift, compare, conditional subtract, quotient bit.
  always_comb begin
    w_trial   = {i_rem, i_work[dividend_width-1]};
    w_div_ext = (dividend_width + 1)'(i_divisor);
    w_div_w   = dividend_width'(i_divisor);
    w_ge      = (w_trial >= w_div_ext);
    // When the trial fits, the difference is below the trial and so fits
    // in dividend_width bits; the dropped carry is always zero.
    w_diff    = w_trial[dividend_width-1:0] - w_div_w;
    if (w_ge) begin
      w_rem_next = w_diff;
    end else begin
      w_rem_next = w_trial[dividend_width-1:0];
    end
    w_work_next = {i_work[dividend_width-2:0], w_ge};
  end

  // Stage valid bit; the only state that is reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
    end
  end

  // Data pipeline registers; contents are don't-care while invalid.
  always_ff @(posedge clock) begin
    r_rem     <= w_rem_next;
    r_work    <= w_work_next;
    r_divisor <= i_divisor;
    r_neg     <= i_neg;
    r_tag     <= i_tag;
  end

  assign o_valid   = r_valid;
  assign o_rem     = r_rem;
  assign o_work    = r_work;
  assign o_divisor = r_divisor;
  assign o_neg     = r_neg;
  assign o_tag     = r_tag;

endmodule : pipelined_divider_stage

// File: rtl/pipelined_divider.sv
// -----------------------------------------------------------------------------
// pipelined_divider
// Fully pipelined signed-dividend / unsigned-divisor divider. Accepts one
// operation per cycle with no backpressure; results emerge in issue order
// dividend_width cycles after the sampling edge (stage 0 + dividend_width
// restoring stages, sign correction combinational at the output).
//
// Quotient truncates toward zero; remainder takes the sign of the dividend.
// A zero divisor yields an all-ones quotient and remainder equal to the
// dividend. divisor_width must not exceed dividend_width.
//
// Ports
//   clock        : rising-edge clock
//   reset        : synchronous active-high reset (clears all valid bits)
//   input_valid  : dividend, divisor and input_tag are sampled this cycle
//   input_tag    : opaque 6-bit tag carried with the operation
//   divisor      : unsigned divisor, divisor_width bits
//   dividend     : two's-complement dividend, dividend_width bits
//   output_valid : quotient, remainder and output_tag valid this cycle
//   output_tag   : tag of the completing operation
//   quotient     : signed quotient, dividend_width bits
//   remainder    : signed remainder, dividend_width bits
// -----------------------------------------------------------------------------
module pipelined_divider
  import pipelined_divider_pkg::*;
#(
  parameter int unsigned dividend_width = 32,
  parameter int unsigned divisor_width  = 24
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      input_valid,
  input  logic [5:0]                input_tag,
  input  logic [divisor_width-1:0]  divisor,
  input  logic [dividend_width-1:0] dividend,
  output logic                      output_valid,
  output logic [5:0]                output_tag,
  output logic [dividend_width-1:0] quotient,
  output logic [dividend_width-1:0] remainder
);

  localparam int unsigned tag_width = TAG_WIDTH;
  localparam int unsigned stages    = dividend_width;

  // Per-stage pipeline signals; index 0 is the input register stage.
  logic                      stage_valid [0:stages];
  logic [dividend_width-1:0] w_rem       [0:stages];
  logic [dividend_width-1:0] w_work      [0:stages];
  logic [divisor_width-1:0]  w_divisor   [0:stages];
  logic                      w_neg       [0:stages];
  logic [tag_width-1:0]      w_tag       [0:stages];

  logic [dividend_width-1:0] w_mag;

  logic                      r_valid0;
  logic [dividend_width-1:0] r_mag;
  logic                      r_neg;
  logic [divisor_width-1:0]  r_divisor;
  logic [tag_width-1:0]      r_tag;

  // Dividend magnitude; the most negative value negates to itself, which is
  // exactly its magnitude when read as unsigned.
  always_comb begin
    if (dividend[dividend_width-1]) begin
      w_mag = -dividend;
    end else begin
      w_mag = dividend;
    end
  end

  // Stage 0 valid bit; input_valid is ignored while reset is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid0 <= 1'b0;
    end else begin
      r_valid0 <= input_valid;
    end
  end

  // Stage 0 data: magnitude, sign, divisor and tag.
  always_ff @(posedge clock) begin
    r_mag     <= w_mag;
    r_neg     <= dividend[dividend_width-1];
    r_divisor <= divisor;
    r_tag     <= input_tag;
  end

  assign stage_valid[0] = r_valid0;
  assign w_rem[0]       = {dividend_width{1'b0}};
  assign w_work[0]      = r_mag;
  assign w_divisor[0]   = r_divisor;
  assign w_neg[0]       = r_neg;
  assign w_tag[0]       = r_tag;

  for (genvar k = 1; k <= stages; k++) begin : g_stage
    pipelined_divider_stage #(
      .dividend_width (dividend_width),
      .divisor_width  (divisor_width)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .i_valid   (stage_valid[k-1]),
      .i_rem     (w_rem[k-1]),
      .i_work    (w_work[k-1]),
      .i_divisor (w_divisor[k-1]),
      .i_neg     (w_neg[k-1]),
      .i_tag     (w_tag[k-1]),
      .o_valid   (stage_valid[k]),
      .o_rem     (w_rem[k]),
      .o_work    (w_work[k]),
      .o_divisor (w_divisor[k]),
      .o_neg     (w_neg[k]),
      .o_tag     (w_tag[k])
    );
  end

  // Sign correction from the last stage. A zero divisor forces an all-ones
  // quotient regardless of sign; its remainder is the magnitude, so negating
  // it for a negative dividend restores the original dividend.
  always_comb begin
    if (w_divisor[stages] == {divisor_width{1'b0}}) begin
      quotient = {dividend_width{1'b1}};
    end else if (w_neg[stages]) begin
      quotient = -w_work[stages];
    end else begin
      quotient = w_work[stages];
    end
    if (w_neg[stages]) begin
      remainder = -w_rem[stages];
    end else begin
      remainder = w_rem[stages];
    end
  end

  assign output_valid = stage_valid[stages];
  assign output_tag   = w_tag[stages];

endmodule : pipelined_divider

// File: tb/tb_pipelined_divider.sv
// -----------------------------------------------------------------------------
// tb_pipelined_divider
// Self-checking bench for pipelined_divider at default parameters. A
// reference model built on 64-bit signed arithmetic predicts each result,
// and a queue of issued operations predicts when output_valid must rise.
// -----------------------------------------------------------------------------
module tb_pipelined_divider;

  localparam int LAT = 33;  // negedge observations from issue to result

  logic        clock;
  logic        reset;
  logic        input_valid;
  logic [5:0]  input_tag;
  logic [23:0] divisor;
  logic [31:0] dividend;
  logic        output_valid;
  logic [5:0]  output_tag;
  logic [31:0] quotient;
  logic [31:0] remainder;

  pipelined_divider #(
    .dividend_width (32),
    .divisor_width  (24)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_tag    (input_tag),
    .divisor      (divisor),
    .dividend     (dividend),
    .output_valid (output_valid),
    .output_tag   (output_tag),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] q;
    logic [31:0] r;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  exp_t        exp_cur;
  bit          exp_valid;
  int          tests_run;
  int          tests_failed;
  int          cyc;
  logic        obs_valid;
  logic [5:0]  obs_tag;
  logic [31:0] obs_q;
  logic [31:0] obs_r;

  // Reference: signed dividend / unsigned divisor, truncating toward zero.
  function automatic void ref_div(input logic [31:0] dvd, input logic [23:0] dvs,
                                  output logic [31:0] q, output logic [31:0] r);
    longint a;
    longint b;
    longint qq;
    longint rr;
    if (dvs == 24'd0) begin
      q = 32'hFFFF_FFFF;
      r = dvd;
    end else begin
      a  = longint'($signed(dvd));
      b  = longint'(dvs);
      qq = a / b;
      rr = a - qq * b;
      q  = qq[31:0];
      r  = rr[31:0];
    end
  endfunction

  function automatic logic [31:0] rand_dvd();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom) >> $urandom_range(0, 31);
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [23:0] rand_dvs();
    case ($urandom_range(0, 7))
      0:       return 24'd0;
      1:       return 24'd1;
      2:       return 24'hFF_FFFF;
      default: return 24'($urandom) >> $urandom_range(0, 23);
    endcase
  endfunction

  // One clock: observe outputs, update the model's expectation, drive inputs.
  task automatic cycle(input bit rst, input bit v, input logic [31:0] dvd,
                       input logic [23:0] dvs, input logic [5:0] tag);
    exp_t e;
    @(negedge clock);
    cyc++;
    obs_valid = output_valid;
    obs_tag   = output_tag;
    obs_q     = quotient;
    obs_r     = remainder;
    exp_valid = (sb.size() > 0) && (cyc - sb[0].issue == LAT);
    if (exp_valid) exp_cur = sb.pop_front();
    reset       = rst;
    input_valid = v;
    dividend    = dvd;
    divisor     = dvs;
    input_tag   = tag;
    if (rst) begin
      sb.delete();
    end else if (v) begin
      e.tag   = tag;
      ref_div(dvd, dvs, e.q, e.r);
      e.issue = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 32'($urandom), 24'($urandom), 6'(i));
      tests_run++;
      if (obs_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_valid cyc %0d: got %b expected 0", cyc, obs_valid);
      end
    end
    for (int i = 0; i < LAT + 5; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 24'd0, 6'd0);
      tests_run++;
      if (obs_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle cyc %0d: got %b expected 0", cyc, obs_valid);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] d_dvd [4];
    logic [23:0] d_dvs [4];
    logic [31:0] d_q   [4];
    logic [31:0] d_r   [4];
    int          idx;
    d_dvd = '{32'd100, 32'hFFFF_FF9C, 32'h7FFF_FFFF, 32'h8000_0000};
    d_dvs = '{24'd7, 24'd7, 24'hFF_FFFF, 24'd1};
    d_q   = '{32'd14, 32'hFFFF_FFF2, 32'd128, 32'h8000_0000};
    d_r   = '{32'd2, 32'hFFFF_FFFE, 32'd127, 32'd0};
    for (int i = 0; i < 4 + LAT + 2; i++) begin
      if (i < 4) cycle(1'b0, 1'b1, d_dvd[i], d_dvs[i], 6'(i + 1));
      else       cycle(1'b0, 1'b0, 32'd0, 24'd0, 6'd0);
      tests_run++;
      if (obs_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL directed_valid cyc %0d: got %b expected %b", cyc, obs_valid, exp_valid);
      end
      if (exp_valid && obs_valid) begin
        idx = int'(exp_cur.tag) - 1;
        tests_run++;
        if ({obs_tag, obs_q, obs_r} !== {exp_cur.tag, d_q[idx], d_r[idx]}) begin
          tests_failed++;
          $display("FAIL directed_result tag %0d: got tag %0d q %h r %h expected q %h r %h",
                   exp_cur.tag, obs_tag, obs_q, obs_r, d_q[idx], d_r[idx]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    for (int i = 0; i < 64 + LAT + 2; i++) begin
      if (i < 64) cycle(1'b0, 1'b1, rand_dvd(), rand_dvs(), 6'(i));
      else        cycle(1'b0, 1'b0, 32'd0, 24'd0, 6'd0);
      tests_run++;
      if (obs_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL b2b_valid cyc %0d: got %b expected %b", cyc, obs_valid, exp_valid);
      end
      if (exp_valid && obs_valid) begin
        seen++;
        tests_run++;
        if ({obs_tag, obs_q, obs_r} !== {exp_cur.tag, exp_cur.q, exp_cur.r}) begin
          tests_failed++;
          $display("FAIL b2b_result cyc %0d: got tag %0d q %h r %h expected tag %0d q %h r %h",
                   cyc, obs_tag, obs_q, obs_r, exp_cur.tag, exp_cur.q, exp_cur.r);
        end
      end
    end
    tests_run++;
    if (seen != 64) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d results expected 64", seen);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 10 + 5 + 1 + LAT + 5; i++) begin
      if (i < 10)      cycle(1'b0, 1'b1, rand_dvd(), rand_dvs(), 6'(i + 20));
      else if (i < 15) cycle(1'b0, 1'b0, 32'd0, 24'd0, 6'd0);
      else if (i == 15) cycle(1'b1, 1'b1, 32'd9, 24'd3, 6'd63);
      else             cycle(1'b0, 1'b0, 32'd0, 24'd0, 6'd0);
      tests_run++;
      if (obs_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_stale cyc %0d: got %b expected 0", cyc, obs_valid);
      end
    end
    for (int i = 0; i < 1 + LAT + 2; i++) begin
      if (i == 0) cycle(1'b0, 1'b1, 32'hFFFF_FC18, 24'd33, 6'd42);
      else        cycle(1'b0, 1'b0, 32'd0, 24'd0, 6'd0);
      tests_run++;
      if (obs_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL midreset_after_valid cyc %0d: got %b expected %b", cyc, obs_valid, exp_valid);
      end
      if (exp_valid && obs_valid) begin
        tests_run++;
        if ({obs_tag, obs_q, obs_r} !== {exp_cur.tag, exp_cur.q, exp_cur.r}) begin
          tests_failed++;
          $display("FAIL midreset_after_result: got tag %0d q %h r %h expected tag %0d q %h r %h",
                   obs_tag, obs_q, obs_r, exp_cur.tag, exp_cur.q, exp_cur.r);
        end
      end
    end
  endtask

  task automatic test_bubbles_div0();
    for (int i = 0; i < 20 + LAT + 2; i++) begin
      if (i < 20) cycle(1'b0, (i % 2) == 0, 32'd5, 24'd0, 6'(i));
      else        cycle(1'b0, 1'b0, 32'd0, 24'd0, 6'd0);
      tests_run++;
      if (obs_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL bubble_valid cyc %0d: got %b expected %b", cyc, obs_valid, exp_valid);
      end
      if (exp_valid && obs_valid) begin
        tests_run++;
        if ({obs_tag, obs_q, obs_r} !== {exp_cur.tag, 32'hFFFF_FFFF, 32'd5}) begin
          tests_failed++;
          $display("FAIL bubble_result cyc %0d: got tag %0d q %h r %h expected tag %0d q ffffffff r 00000005",
                   cyc, obs_tag, obs_q, obs_r, exp_cur.tag);
        end
      end
    end
  endtask

  task automatic test_random_bubbles();
    for (int i = 0; i < 150 + LAT + 2; i++) begin
      if (i < 150) cycle(1'b0, $urandom_range(0, 2) != 0, rand_dvd(), rand_dvs(), 6'($urandom));
      else         cycle(1'b0, 1'b0, 32'd0, 24'd0, 6'd0);
      tests_run++;
      if (obs_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL rand_valid cyc %0d: got %b expected %b", cyc, obs_valid, exp_valid);
      end
      if (exp_valid && obs_valid) begin
        tests_run++;
        if ({obs_tag, obs_q, obs_r} !== {exp_cur.tag, exp_cur.q, exp_cur.r}) begin
          tests_failed++;
          $display("FAIL rand_result cyc %0d: got tag %0d q %h r %h expected tag %0d q %h r %h",
                   cyc, obs_tag, obs_q, obs_r, exp_cur.tag, exp_cur.q, exp_cur.r);
        end
      end
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d outstanding expected 0", sb.size());
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    reset        = 1'b1;
    input_valid  = 1'b0;
    input_tag    = 6'd0;
    divisor      = 24'd0;
    dividend     = 32'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_bubbles_div0();
    test_random_bubbles();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pipelined_divider
